t08_gpio_arbiter: RTL and testbench
===================================

# t08_gpio_arbiter

Shares the 34 breakout-board GPIO pins between several on-chip peripheral requesters inside the team_08 design. It grants exclusive pin ownership with round-robin fairness and a bounded hold time. It inserts a bus-release turnaround between owners so no two drivers ever contend. It sits between the t08 peripheral blocks and the top-level gpio_out/gpio_oeb ports, and obeys the chip enable.

## Interface
Parameters:
- NREQ, 3: number of requesters (2..8).
- WIDTH, 34: GPIO pins managed.
- MAX_HOLD, 255: cycles an owner may hold the pins before being preempted when another request is pending (>=1).
- TURNAROUND, 1: release cycles between owners (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  chip enable; low forces release and idle.
- req  input  NREQ  per-requester pin request, level-sensitive.
- req_out  input  NREQ*WIDTH  requester i drive values at bits [i*WIDTH +: WIDTH].
- req_oeb  input  NREQ*WIDTH  requester i active-low output enables, same packing.
- gnt  output  NREQ  one-hot grant, registered.
- owner  output  $clog2(NREQ)  index of current/last owner, registered.
- busy  output  1  high in GRANT or TURN.
- gpio_out  output  WIDTH  to pads.
- gpio_oeb  output  WIDTH  to pads, active low.

## Operation
- State machine with states IDLE, GRANT and TURN.
- IDLE:
  - If en and any req bit is set, pick the first set bit searching from (last_owner+1) mod NREQ upward with wrap.
  - Load owner with that index, assert its gnt bit, clear hold_cnt, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gpio_out = owner's req_out slice; gpio_oeb = owner's req_oeb slice. This is a combinational mux from registered owner/state.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Go to TURN, deasserting gnt, when either:
    - req[owner] is low (voluntary release), or
    - hold_cnt == MAX_HOLD and some other req bit is set (preemption).
  - With no other request pending, the owner holds indefinitely.
- TURN:
  - gpio_oeb = all ones and gpio_out = 0.
  - Stay for TURNAROUND cycles, using a counter, then go to IDLE.
  - last_owner = owner, so the preempted or released requester has lowest priority next.
- In IDLE and after reset, pins are released: gpio_oeb all ones, gpio_out 0.
- en low, sampled at any edge:
  - Next state is IDLE, gnt clears, and pins are released at that edge.
  - last_owner is preserved.
  - No arbitration happens while en is low.
- A requester that drops req and re-raises it in the same TURN cycle competes normally in IDLE. Round-robin still places it last.
- gnt is never asserted for a requester whose req is low at the arbitration edge.

## Timing
- Reset (rst high at an edge), applied in any state including mid-GRANT:
  - state IDLE, gnt 0, owner 0, last_owner NREQ-1 (requester 0 wins first), hold_cnt 0, busy 0.
  - gpio_oeb all ones, gpio_out 0.
- Grant latency: req rises before edge k while in IDLE → gnt high after edge k. Pins follow the owner from the same cycle.
- Release: req[owner] low before edge k → gnt low after edge k. TURN lasts cycles k..k+TURNAROUND-1, IDLE follows, and the next gnt appears after edge k+TURNAROUND+1.
- Handoff gap between two owners is TURNAROUND+1 cycles with no grant and pins released.
- Preemption: with a competing request, the owner keeps gnt for exactly MAX_HOLD+1 cycles, counting the grant cycle as count 0.
- Simultaneous requests in IDLE: round-robin order from last_owner+1; exactly one grant.
- rst has priority over en, and en over all state transitions.

## Test plan
- Reset then req=3'b111, en=1 → gnt=001 one cycle later, owner=0. Then gnt sequence 001, 010, 100, 001 under preemption, with 2-cycle pin-release gaps (TURNAROUND=1).
- req=3'b010 held alone for 1000 cycles, MAX_HOLD=255 → gnt stays 010 and gpio_out tracks req_out slice 1 every cycle.
- Owner 1 holding, req[2] rises at cycle 10 after grant → gnt drops after hold_cnt reaches 255, gpio_oeb=all ones for 1 cycle, gnt=100 two cycles later.
- Owner 0 drops req → gnt=000 next cycle. While busy in TURN, gpio_oeb=0x3_FFFF_FFFF and gpio_out=0 for TURNAROUND cycles.
- en low mid-GRANT → next cycle gnt=0, busy=0, pins released. en high with req=3'b001 and last owner 0 → owner 0 regranted one cycle after en returns.
- rst asserted mid-GRANT, then rst low with req=3'b110 → gnt=010, confirming requester 1 wins and last_owner was reset.

Source files
------------

// File: rtl/t08_gpio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t08_gpio_arbiter
// Purpose  : Round-robin GPIO pin ownership arbiter with bounded hold time and
//            a release turnaround between owners.
// Revision : 1.0
// ============================================================================
module t08_gpio_arbiter #(
    parameter int NREQ       = 3,
    parameter int WIDTH      = 34,
    parameter int MAX_HOLD   = 255,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_out,
    input  logic [NREQ*WIDTH-1:0]      req_oeb,
    output logic [NREQ-1:0]            gnt,
    output logic [$clog2(NREQ)-1:0]    owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           gpio_out,
    output logic [WIDTH-1:0]           gpio_oeb
);

    localparam int c_OW = $clog2(NREQ);
    localparam int c_HW = $clog2(MAX_HOLD + 1);
    localparam int c_TW = $clog2(TURNAROUND + 1);
    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [c_OW-1:0]   r_owner, w_owner_nxt;
    logic [c_OW-1:0]   r_last_owner, w_last_nxt;
    logic [c_HW-1:0]   r_hold_cnt, w_hold_nxt;
    logic [c_TW-1:0]   r_turn_cnt, w_turn_nxt;

    logic              w_found;
    logic [c_OW-1:0]   w_pick;
    logic [NREQ-1:0]   w_own_mask;
    logic              w_own_req;
    logic              w_others;
    logic              w_hold_max;
    logic [WIDTH-1:0]  w_sel_out;
    logic [WIDTH-1:0]  w_sel_oeb;

    // Round-robin: the winner is the requester with the smallest forward
    // distance from the slot just after the last owner.
    always_comb begin
        int v_dist;
        int v_best;
        v_dist  = 0;
        v_best  = NREQ;
        w_found = 1'b0;
        w_pick  = '0;
        for (int j = 0; j < NREQ; j++) begin
            v_dist = (j + 2 * NREQ - 1 - int'(r_last_owner)) % NREQ;
            if (req[j] && (v_dist < v_best)) begin
                v_best  = v_dist;
                w_pick  = c_OW'(j);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_out = '0;
        w_sel_oeb = '1;
        for (int j = 0; j < NREQ; j++) begin
            if (r_owner == c_OW'(j)) begin
                w_sel_out = req_out[j*WIDTH +: WIDTH];
                w_sel_oeb = req_oeb[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_own_mask = c_ONE << r_owner;
    assign w_own_req  = |(req & w_own_mask);
    assign w_others   = |(req & ~w_own_mask);
    assign w_hold_max = (r_hold_cnt == c_HW'(MAX_HOLD));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_hold_nxt  = r_hold_cnt;
        w_turn_nxt  = r_turn_cnt;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
            w_turn_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        w_state_nxt = S_GRANT;
                        w_owner_nxt = w_pick;
                        w_gnt_nxt   = c_ONE << w_pick;
                        w_hold_nxt  = '0;
                    end
                end
                S_GRANT: begin
                    if (!w_own_req || (w_hold_max && w_others)) begin
                        w_state_nxt = S_TURN;
                        w_gnt_nxt   = '0;
                        w_last_nxt  = r_owner;
                        w_turn_nxt  = '0;
                    end else if (!w_hold_max) begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    if (r_turn_cnt == c_TW'(TURNAROUND - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_turn_nxt  = '0;
                    end else begin
                        w_turn_nxt = r_turn_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= c_OW'(NREQ - 1);
            r_hold_cnt   <= '0;
            r_turn_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_turn_cnt   <= w_turn_nxt;
        end
    end

    // Pins are driven only while an owner holds them; every other state releases.
    assign gpio_out = (r_state == S_GRANT) ? w_sel_out : '0;
    assign gpio_oeb = (r_state == S_GRANT) ? w_sel_oeb : '1;
    assign gnt      = r_gnt;
    assign owner    = r_owner;
    assign busy     = (r_state == S_GRANT) || (r_state == S_TURN);

endmodule
`default_nettype wire

// File: tb/tb_t08_gpio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t08_gpio_arbiter
// Purpose  : Directed self-checking bench for t08_gpio_arbiter.
// Revision : 1.0
// ============================================================================
module tb_t08_gpio_arbiter;

    localparam int NREQ = 3;
    localparam int WIDTH = 34;
    localparam int MAX_HOLD = 255;
    localparam int TA = 1;

    logic                  clk = 1'b0;
    logic                  rst, en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_out, req_oeb;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic                  busy;
    logic [WIDTH-1:0]      gpio_out, gpio_oeb;

    int checks = 0;
    int failures = 0;

    t08_gpio_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TA)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_out(req_out), .req_oeb(req_oeb),
        .gnt(gnt), .owner(owner), .busy(busy),
        .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the pins, how long they have held them, and
    // how many release cycles remain before arbitration may happen again.
    bit m_ready = 1'b0;
    bit m_act;
    int m_owner, m_last, m_held, m_gap;

    always @(posedge clk) begin
        logic [NREQ-1:0] others;
        bit found;
        int c;
        if (rst) begin
            m_ready = 1'b1;
            m_act = 1'b0; m_owner = 0; m_last = NREQ - 1; m_held = 0; m_gap = 0;
        end else if (!en) begin
            m_act = 1'b0; m_gap = 0; m_held = 0;
        end else if (m_act) begin
            others = req & ~(NREQ'(1) << m_owner);
            if (((req >> m_owner) & NREQ'(1)) == '0 || (m_held == MAX_HOLD && others != '0)) begin
                m_act = 1'b0; m_last = m_owner; m_gap = TA;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (!found && ((req >> c) & NREQ'(1)) != '0) begin
                    found = 1'b1; m_act = 1'b1; m_owner = c; m_held = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic [WIDTH-1:0] eo, ee;
        if (m_ready) begin
            eg = m_act ? (NREQ'(1) << m_owner) : '0;
            eo = m_act ? WIDTH'(req_out >> (m_owner * WIDTH)) : '0;
            ee = m_act ? WIDTH'(req_oeb >> (m_owner * WIDTH)) : '1;
            check("model_gnt", 64'(gnt), 64'(eg));
            check("model_owner", 64'(owner), 64'(m_owner));
            check("model_busy", 64'(busy), 64'(m_act || m_gap > 0));
            check("model_gpio_out", 64'(gpio_out), 64'(eo));
            check("model_gpio_oeb", 64'(gpio_oeb), 64'(ee));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called on the negedge of a grant cycle for g; checks the preemption
    // run length, the turnaround cycle, the idle cycle and the next owner.
    task automatic rotate(input string name, input logic [NREQ-1:0] g, input logic [NREQ-1:0] gnext);
        int n;
        n = 0;
        while (gnt == g && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({name, "_hold_len"}, 64'(n), 64'(MAX_HOLD + 1));
        check({name, "_turn_oeb"}, 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        check({name, "_turn_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({name, "_idle_gnt"}, 64'(gnt), 64'd0);
        @(negedge clk);
        check({name, "_next_gnt"}, 64'(gnt), 64'(gnext));
    endtask

    logic [WIDTH-1:0] s1;

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; req = '0;
        req_out = {34'h3_0F0F_F0F0, 34'h2_AAAA_5555, 34'h1_2345_6789};
        req_oeb = {34'h0_0000_0000, 34'h3_FFFF_0000, 34'h0_0000_00FF};
        repeat (3) tick();
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        check("rst_out", 64'(gpio_out), 64'd0);

        // All three request: 0 first, then rotation under preemption.
        tick();
        rst = 1'b0; en = 1'b1; req = 3'b111;
        tick();
        @(negedge clk);
        check("first_gnt", 64'(gnt), 64'd1);
        check("first_owner", 64'(owner), 64'd0);
        check("first_out", 64'(gpio_out), 64'h1_2345_6789);
        check("first_oeb", 64'(gpio_oeb), 64'h0_0000_00FF);
        rotate("rr0", 3'b001, 3'b010);
        rotate("rr1", 3'b010, 3'b100);
        rotate("rr2", 3'b100, 3'b001);

        // Lone requester 1 holds indefinitely while its drive values change.
        tick();
        req = 3'b010;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i % 250 == 0) begin
                s1 = 34'h1_0000_0000 + WIDTH'(i * 7 + 3);
                req_out[WIDTH +: WIDTH] = s1;
            end
        end
        @(negedge clk);
        check("lone_gnt", 64'(gnt), 64'b010);
        check("lone_out", 64'(gpio_out), 64'(s1));

        // Fresh grant to 1, requester 2 arrives 11 cycles later.
        tick();
        req = 3'b000;
        repeat (3) tick();
        req = 3'b010;
        tick();
        @(negedge clk);
        check("pre_gnt", 64'(gnt), 64'b010);
        n = 1;
        repeat (10) begin
            @(negedge clk);
            if (gnt == 3'b010) n++;
        end
        @(posedge clk);
        #2;
        req = 3'b110;
        @(negedge clk);
        while (gnt == 3'b010 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("pre_hold_len", 64'(n), 64'd256);
        check("pre_turn_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        @(negedge clk);
        check("pre_idle_gnt", 64'(gnt), 64'd0);
        @(negedge clk);
        check("pre_next_gnt", 64'(gnt), 64'b100);

        // Owner 2 releases, 0 wins; then 0 releases voluntarily.
        @(posedge clk);
        #2;
        req = 3'b001;
        repeat (4) @(negedge clk);
        check("rel_gnt0", 64'(gnt), 64'b001);
        @(posedge clk);
        #2;
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("rel_gnt", 64'(gnt), 64'd0);
        check("rel_busy", 64'(busy), 64'd1);
        check("rel_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        check("rel_out", 64'(gpio_out), 64'd0);

        // Chip enable drop mid-grant, then return.
        @(posedge clk);
        #2;
        req = 3'b001;
        n = 0;
        while (gnt == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("en_pre_gnt", 64'(gnt), 64'b001);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_low_gnt", 64'(gnt), 64'd0);
        check("en_low_busy", 64'(busy), 64'd0);
        check("en_low_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        repeat (3) @(negedge clk);
        check("en_low_hold", 64'(gnt), 64'd0);
        @(posedge clk);
        #2;
        en = 1'b1;
        @(negedge clk);
        check("en_ret_nogrant", 64'(gnt), 64'd0);
        @(negedge clk);
        check("en_ret_gnt", 64'(gnt), 64'b001);
        check("en_ret_owner", 64'(owner), 64'd0);

        // Reset mid-grant restores last_owner so requester 0 is favoured next.
        @(posedge clk);
        #2;
        rst = 1'b1; req = 3'b110;
        repeat (2) @(negedge clk);
        check("rst2_gnt", 64'(gnt), 64'd0);
        check("rst2_owner", 64'(owner), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_win_gnt", 64'(gnt), 64'b010);
        check("rst2_win_owner", 64'(owner), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1; req = 3'b101;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst3_win_gnt", 64'(gnt), 64'b001);
        check("rst3_win_owner", 64'(owner), 64'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
